// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: source, mask, claim/complete and status signals between the interrupt aggregator and its environment.
interface irq_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int IDW     = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0] src_i;
  logic               en_we_i;
  logic [NUM_SRC-1:0] en_wdata_i;
  logic               irq_ack_i;
  logic               complete_i;
  logic [IDW-1:0]     complete_id_i;
  logic               meip_o;
  logic [IDW-1:0]     claim_id_o;
  logic               claim_valid_o;
  logic [NUM_SRC-1:0] pending_o;
  modport slave (
    input  src_i, en_we_i, en_wdata_i, irq_ack_i, complete_i, complete_id_i,
    output meip_o, claim_id_o, claim_valid_o, pending_o
  );
  modport master (
    output src_i, en_we_i, en_wdata_i, irq_ack_i, complete_i, complete_id_i,
    input  meip_o, claim_id_o, claim_valid_o, pending_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronises external interrupt sources, latches pending bits, picks the lowest-index
// enabled winner and runs a non-nested claim/complete handshake in front of the core's meip input.
module irq_ctrl #(
  parameter int                 NUM_SRC     = 4,
  parameter int                 IDW         = $clog2(NUM_SRC),
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] LEVEL_MASK  = '0,
  parameter logic [NUM_SRC-1:0] EN_RESET    = '1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  irq_ctrl_if.slave  bus
);
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] prev_q, pending_q, pending_d, in_service_q, in_service_d, en_q, en_d;
  logic [NUM_SRC-1:0] level, rise, eligible, claim_oh;
  logic [IDW-1:0]     claim_id_q, claim_id_d, winner;
  logic               in_svc, meip, claim, complete;
  assign level    = sync_q[SYNC_STAGES-1];
  assign rise     = level & ~prev_q;
  assign eligible = pending_q & en_q;
  assign in_svc   = |in_service_q;
  assign meip     = |eligible & ~in_svc;
  assign claim    = bus.irq_ack_i & meip;
  assign complete = bus.complete_i & in_svc & (bus.complete_id_i == claim_id_q);
  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (eligible[i]) winner = IDW'(i);
  end
  assign claim_oh = claim ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << winner) : '0;
  // Edge sets beat a same-cycle claim; level sets are suppressed while claimed or in service.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.src_i};
    pending_d    = (pending_q & ~claim_oh)
                 | (rise & ~LEVEL_MASK)
                 | (level & LEVEL_MASK & ~in_service_q & ~claim_oh);
    in_service_d = claim ? claim_oh : (complete ? '0 : in_service_q);
    claim_id_d   = claim ? winner : claim_id_q;
    en_d         = bus.en_we_i ? bus.en_wdata_i : en_q;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q       <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      en_q         <= EN_RESET;
      claim_id_q   <= '0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= level;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      en_q         <= en_d;
      claim_id_q   <= claim_id_d;
    end
  end
  assign bus.meip_o        = meip;
  assign bus.claim_id_o    = claim_id_q;
  assign bus.claim_valid_o = in_svc;
  assign bus.pending_o     = pending_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vectors for an edge-mode instance plus hand sequences for level mode and async reset.
module tb_irq_ctrl;
  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  int   tests = 0;
  int   fails = 0;
  always #5 clk_i = ~clk_i;
  irq_ctrl_if #(.NUM_SRC(4)) ia ();
  irq_ctrl_if #(.NUM_SRC(4)) ib ();
  irq_ctrl #(.NUM_SRC(4)) dut_a (.clk_i(clk_i), .reset_i(reset_i), .bus(ia));
  irq_ctrl #(.NUM_SRC(4), .LEVEL_MASK(4'b0001)) dut_b (.clk_i(clk_i), .reset_i(reset_i), .bus(ib));
  typedef struct {
    logic [3:0] src;
    logic       we;
    logic [3:0] wd;
    logic       ack;
    logic       cmp;
    logic [1:0] cid;
    logic       meip;
    logic       cv;
    logic [1:0] id;
    logic [3:0] pend;
  } vec_t;
  vec_t vt[$];
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_out(input string nm, input logic meip, input logic cv, input logic [1:0] id,
                         input logic [3:0] pend, input logic m, input logic c, input logic [1:0] i,
                         input logic [3:0] p);
    chk({nm, ".meip"}, int'(meip), int'(m));
    chk({nm, ".valid"}, int'(cv), int'(c));
    chk({nm, ".id"}, int'(id), int'(i));
    chk({nm, ".pend"}, int'(pend), int'(p));
  endtask
  task automatic idle(input bit b);
    if (b) begin
      ib.en_we_i = 1'b0; ib.en_wdata_i = 4'h0; ib.irq_ack_i = 1'b0;
      ib.complete_i = 1'b0; ib.complete_id_i = 2'd0;
    end else begin
      ia.en_we_i = 1'b0; ia.en_wdata_i = 4'h0; ia.irq_ack_i = 1'b0;
      ia.complete_i = 1'b0; ia.complete_id_i = 2'd0;
    end
  endtask
  initial begin
    //            src   we    wd    ack   cmp   cid   meip  cv    id    pend
    vt.push_back('{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0});
    vt.push_back('{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0});
    vt.push_back('{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h4});
    vt.push_back('{4'h4, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'h0});
    vt.push_back('{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'h0});
    vt.push_back('{4'h4, 1'b0, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd2, 4'h0});
    vt.push_back('{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 4'h0});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 4'h0});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 4'h0});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 4'hA});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 4'h8});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 4'h8});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 4'h8});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd1, 4'h8});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3, 4'h0});
    vt.push_back('{4'hE, 1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd3, 4'h0});
    vt.push_back('{4'hE, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 4'h0});
    vt.push_back('{4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 4'h0});
    vt.push_back('{4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 4'h0});
    vt.push_back('{4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 4'h1});
    vt.push_back('{4'hF, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 4'h1});
    vt.push_back('{4'hF, 1'b1, 4'h1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 4'h1});
    vt.push_back('{4'hF, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'h0});
    vt.push_back('{4'hF, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0});
    vt.push_back('{4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0});
    vt.push_back('{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0});
    vt.push_back('{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0});
    vt.push_back('{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0});
    idle(1'b0);
    idle(1'b1);
    ia.src_i = 4'h0;
    ib.src_i = 4'h0;
    // Reset held with toggling sources: everything stays quiet.
    for (int i = 0; i < 20; i++) begin
      ia.src_i = 4'(i);
      ib.src_i = 4'(~i);
      ia.irq_ack_i = 1'(i);
      tick();
      chk_out($sformatf("rst%0d.a", i), ia.meip_o, ia.claim_valid_o, ia.claim_id_o, ia.pending_o,
              1'b0, 1'b0, 2'd0, 4'h0);
      if (i % 5 == 4)
        chk_out($sformatf("rst%0d.b", i), ib.meip_o, ib.claim_valid_o, ib.claim_id_o, ib.pending_o,
                1'b0, 1'b0, 2'd0, 4'h0);
    end
    idle(1'b0);
    ia.src_i = 4'h0;
    ib.src_i = 4'h0;
    reset_i = 1'b1;
    tick();
    foreach (vt[k]) begin
      ia.src_i = vt[k].src;
      ia.en_we_i = vt[k].we;
      ia.en_wdata_i = vt[k].wd;
      ia.irq_ack_i = vt[k].ack;
      ia.complete_i = vt[k].cmp;
      ia.complete_id_i = vt[k].cid;
      tick();
      chk_out($sformatf("vec%0d", k), ia.meip_o, ia.claim_valid_o, ia.claim_id_o, ia.pending_o,
              vt[k].meip, vt[k].cv, vt[k].id, vt[k].pend);
    end
    idle(1'b0);
    // Level mode: re-assert after completion while still high.
    ib.src_i = 4'h1;
    tick();
    tick();
    chk("lvl.lat2", int'(ib.meip_o), 0);
    tick();
    chk_out("lvl.fire", ib.meip_o, ib.claim_valid_o, ib.claim_id_o, ib.pending_o, 1'b1, 1'b0, 2'd0, 4'h1);
    ib.irq_ack_i = 1'b1;
    tick();
    ib.irq_ack_i = 1'b0;
    chk_out("lvl.claim", ib.meip_o, ib.claim_valid_o, ib.claim_id_o, ib.pending_o, 1'b0, 1'b1, 2'd0, 4'h0);
    tick();
    chk_out("lvl.svc", ib.meip_o, ib.claim_valid_o, ib.claim_id_o, ib.pending_o, 1'b0, 1'b1, 2'd0, 4'h0);
    ib.complete_i = 1'b1;
    tick();
    ib.complete_i = 1'b0;
    chk_out("lvl.cmp", ib.meip_o, ib.claim_valid_o, ib.claim_id_o, ib.pending_o, 1'b0, 1'b0, 2'd0, 4'h0);
    tick();
    chk_out("lvl.refire", ib.meip_o, ib.claim_valid_o, ib.claim_id_o, ib.pending_o, 1'b1, 1'b0, 2'd0, 4'h1);
    ib.irq_ack_i = 1'b1;
    tick();
    ib.irq_ack_i = 1'b0;
    ib.src_i = 4'h0;
    chk("lvl.claim2", int'(ib.claim_valid_o), 1);
    for (int i = 0; i < 3; i++) tick();
    ib.complete_i = 1'b1;
    tick();
    ib.complete_i = 1'b0;
    chk("lvl.cmp2", int'(ib.claim_valid_o), 0);
    tick();
    chk_out("lvl.quiet", ib.meip_o, ib.claim_valid_o, ib.claim_id_o, ib.pending_o, 1'b0, 1'b0, 2'd0, 4'h0);
    // Async reset in the middle of a service period.
    ia.src_i = 4'h4;
    for (int i = 0; i < 3; i++) tick();
    chk("ar.fire", int'(ia.meip_o), 1);
    ia.irq_ack_i = 1'b1;
    tick();
    ia.irq_ack_i = 1'b0;
    chk_out("ar.claim", ia.meip_o, ia.claim_valid_o, ia.claim_id_o, ia.pending_o, 1'b0, 1'b1, 2'd2, 4'h0);
    #2;
    reset_i = 1'b0;
    #1;
    chk_out("ar.drop", ia.meip_o, ia.claim_valid_o, ia.claim_id_o, ia.pending_o, 1'b0, 1'b0, 2'd0, 4'h0);
    tick();
    reset_i = 1'b1;
    ia.src_i = 4'h0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised external-interrupt aggregator in front of the core's single `meip_i` input.
- Synchronises NUM_SRC asynchronous sources and latches per-source pending bits, each source in edge or level mode.
- Applies a software-writable enable mask and selects the winner by fixed priority (lowest index wins).
- Drives the core's `meip_i` and runs a claim (core `irq_ack_o`) / complete handshake with one source in service at a time (non-nested).

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..32).
- IDW, $clog2(NUM_SRC), width of source ID fields.
- SYNC_STAGES, 2, synchroniser flops per source (>=2).
- LEVEL_MASK, {NUM_SRC{1'b0}}, per-source mode: 1 = level-sensitive, 0 = rising-edge.
- EN_RESET, {NUM_SRC{1'b1}}, reset value of the enable mask.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous reset, active-low.
- src_i  in  NUM_SRC  raw asynchronous interrupt sources.
- en_we_i  in  1  enable-mask write strobe.
- en_wdata_i  in  NUM_SRC  new enable mask.
- irq_ack_i  in  1  claim strobe from the core (core `irq_ack_o`).
- complete_i  in  1  completion strobe.
- complete_id_i  in  IDW  ID being completed.
- meip_o  out  1  interrupt request to the core (core `meip_i`).
- claim_id_o  out  IDW  ID of the source currently in service.
- claim_valid_o  out  1  a source is in service.
- pending_o  out  NUM_SRC  raw pending bits, for debug.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - All synchroniser, edge-detect, pending and in_service registers go to 0; enable goes to EN_RESET.
  - Outputs: meip_o=0, claim_id_o=0, claim_valid_o=0, pending_o=0.
  - Reset mid-service drops the service with no completion required.
- Synchroniser: src_i[n] first sampled at edge k appears at stage SYNC_STAGES-1 at edge k+SYNC_STAGES-1.
- Edge mode: a synchronised 0->1 transition sets pending[n] at edge k+SYNC_STAGES. A source held high produces one event only.
- Level mode:
  - pending[n] is set on any edge where the synchronised level is 1 and in_service[n]=0.
  - It is not set while the source is in service.
  - If the level is still high after completion, pending re-asserts on the next edge.
- Disabled sources still latch pending but are not eligible. Enabling a source that is already pending makes it eligible on the next edge.
- Eligibility: eligible = pending & enable. The winner is the lowest set index of eligible.
- meip_o = |eligible & ~|in_service.
  - It is a combinational function of registers only, so it is glitch-free.
  - Latency from the first sampling edge of src_i to meip_o high is SYNC_STAGES+1 edges (3 at default).
- Claim (edge where irq_ack_i=1 and meip_o=1):
  - claim_id_o <= winner.
  - in_service[winner] <= 1, pending[winner] <= 0.
  - claim_valid_o <= 1; meip_o falls immediately after this edge.
  - irq_ack_i while meip_o=0 is ignored, with no state change.
- Complete (edge where complete_i=1, claim_valid_o=1 and complete_id_i==claim_id_o):
  - in_service <= 0 and claim_valid_o <= 0.
  - claim_id_o holds its last value.
  - Mismatched ID or no source in service: ignored.
- Simultaneous events:
  - A new edge event on the source being claimed in the same cycle: set wins, pending stays 1 (edge mode only; level mode is blocked by the in_service condition next cycle).
  - Claim and complete cannot coincide, because a claim requires nothing in service; a complete in that cycle is ignored.
  - en_we_i and a claim in the same cycle: the claim uses the old mask; the new mask applies from the next edge.
- claim_valid_o == |in_service at all times. At most one in_service bit is ever set.

Test Plan:
1. Reset check: hold reset_i=0 for 20 cycles, all sources toggling -> all outputs 0; after release, enable == EN_RESET.
2. Edge mode, default parameters:
   - src_i[2] 0->1 held high -> meip_o=1 exactly 3 edges after the first sampling edge.
   - Pulse irq_ack_i one cycle -> claim_id_o=2, claim_valid_o=1, meip_o=0.
   - complete_i with ID 2 -> claim_valid_o=0; no re-fire while src_i[2] stays high.
3. Priority and non-nesting:
   - Raise src_i[3] and src_i[1] together; first claim -> ID 1, and meip_o stays 0 while ID 1 is in service even though 3 is pending.
   - complete(1) -> meip_o=1; next claim -> ID 3.
4. Level mode, LEVEL_MASK=4'b0001:
   - src_i[0] held high, claim, complete -> pending re-asserts on the next edge and meip_o=1 again.
   - Deassert src_i[0] before completing -> after completion meip_o stays 0.
5. Mask and ignored strobes:
   - Write enable=4'b0000 via en_we_i, raise src_i[0] (edge mode) -> pending_o[0]=1, meip_o=0.
   - Write enable=4'b0001 -> meip_o=1 on the next edge.
   - irq_ack_i while meip_o=0 -> no change.
   - complete_id_i mismatch -> claim_valid_o stays 1.
6. Reset mid-service: claim ID 2, then pulse reset_i low for 1 cycle -> claim_valid_o=0, pending_o=0, meip_o=0 immediately (asynchronously).
